// File: rtl/eth_axis_pkg.sv
// Shared helpers and the FIFO entry layout for the Ethernet TX width down-converter.
// Pure declarations, no logic.
// Widths are computed from the IN_BYTES/OUT_BYTES parameters of the instantiating block.
package eth_axis_pkg;

  // Number of output beats that make up one full input word
  function automatic int beats_per_word(input int in_bytes, input int out_bytes);
    return in_bytes / out_bytes;
  endfunction

  // Index width for a counter over n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IN_BYTES = 4;
  localparam int DEF_BC_W     = 2;

  // FIFO entry for the default 4-byte input word; the top re-declares the same
  // field order sized from its own parameters.
  typedef struct packed {
    logic                      tuser;
    logic                      tlast;
    logic [DEF_BC_W-1:0]       byte_count;
    logic [8*DEF_IN_BYTES-1:0] tdata;
  } tx_entry_t;

endpackage

// File: rtl/eth_sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty flags and a fill level.
// Latency: rd_data is valid on the cycle after the read edge.
// Backpressure: writes while full and reads while empty are ignored.
module eth_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     m_clk_i,
  input  logic                     m_rstn_i,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  // A full FIFO refuses writes even when a read happens on the same edge
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // Storage array, no reset needed since pointers gate every access
  always_ff @(posedge m_clk_i) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  // Pointers, occupancy and the registered read port
  always_ff @(posedge m_clk_i) begin
    if (!m_rstn_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/eth_axis_tx_downsizer.sv
// AXIS width down-converter: IN_BYTES words in, OUT_BYTES beats out, via a DEPTH-word FIFO.
// Latency: two cycles from input accept to first output beat when everything is empty.
// Backpressure: s_axis_tready follows FIFO space; outputs hold while m_axis_tready is low.
module eth_axis_tx_downsizer
  import eth_axis_pkg::*;
#(
  parameter int IN_BYTES  = 4,
  parameter int OUT_BYTES = 1,
  parameter int DEPTH     = 16
) (
  input  logic                              s_clk_i,
  input  logic                              s_rstn_i,
  input  logic [8*IN_BYTES-1:0]             s_axis_tdata,
  input  logic [idx_width(IN_BYTES)-1:0]    s_axis_byte_count,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tuser,
  output logic [8*OUT_BYTES-1:0]            m_axis_tdata,
  output logic [OUT_BYTES-1:0]              m_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic [$clog2(DEPTH):0]            fifo_level_o
);
  localparam int R        = beats_per_word(IN_BYTES, OUT_BYTES);
  localparam int IDXW     = idx_width(R);
  localparam int BCW      = idx_width(IN_BYTES);
  localparam int OB_BITS  = 8 * OUT_BYTES;
  localparam int OB_SHIFT = $clog2(OUT_BYTES);

  typedef struct packed {
    logic                  tuser;
    logic                  tlast;
    logic [BCW-1:0]        byte_count;
    logic [8*IN_BYTES-1:0] tdata;
  } entry_t;

  entry_t          wr_entry, rd_entry, ow;
  logic            live_q, fifo_full, fifo_empty, fifo_rd, fifo_wr;
  logic            pf_vld, ow_vld, beat_hs, is_final, take;
  logic [IDXW-1:0] beat_idx, final_idx;

  assign s_axis_tready = live_q && !fifo_full;
  assign fifo_wr       = s_axis_tvalid && s_axis_tready;
  assign wr_entry      = '{tuser: s_axis_tuser, tlast: s_axis_tlast,
                           byte_count: s_axis_byte_count, tdata: s_axis_tdata};

  eth_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .m_clk_i  (s_clk_i),
    .m_rstn_i (s_rstn_i),
    .wr_en    (fifo_wr),
    .wr_data  (wr_entry),
    .rd_en    (fifo_rd),
    .rd_data  (rd_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level_o)
  );

  // Last beat of the held word: truncated on the frame's last word, full otherwise
  always_comb begin
    final_idx = ow.tlast ? IDXW'(ow.byte_count >> OB_SHIFT) : IDXW'(R - 1);
    is_final  = (beat_idx == final_idx);
    beat_hs   = ow_vld && m_axis_tready;
    // rd_entry holds a prefetched word whenever pf_vld is set; hand it over
    // as soon as the holding register frees up so words run back to back
    take      = pf_vld && (!ow_vld || (beat_hs && is_final));
    fifo_rd   = !fifo_empty && (!pf_vld || take);
  end

  // Hold tready low through reset and for the first cycle out of it
  always_ff @(posedge s_clk_i) begin
    live_q <= s_rstn_i;
  end

  // Prefetch flag, holding register and beat counter
  always_ff @(posedge s_clk_i) begin
    if (!s_rstn_i) begin
      pf_vld   <= 1'b0;
      ow_vld   <= 1'b0;
      ow       <= '0;
      beat_idx <= '0;
    end else begin
      if (fifo_rd)   pf_vld <= 1'b1;
      else if (take) pf_vld <= 1'b0;

      if (take) begin
        ow       <= rd_entry;
        ow_vld   <= 1'b1;
        beat_idx <= '0;
      end else if (beat_hs) begin
        if (is_final) begin
          ow_vld   <= 1'b0;
          beat_idx <= '0;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end
    end
  end

  // Beat decode from registered state only, so outputs cannot move during a stall
  always_comb begin
    m_axis_tvalid = ow_vld;
    m_axis_tdata  = ow.tdata[int'(beat_idx)*OB_BITS +: OB_BITS];
    m_axis_tlast  = ow_vld && ow.tlast && is_final;
    m_axis_tuser  = ow_vld && ow.tuser;
    m_axis_tkeep  = ow_vld ? '1 : '0;
    if (m_axis_tlast) begin
      for (int i = 0; i < OUT_BYTES; i++) begin
        m_axis_tkeep[i] = (i <= (int'(ow.byte_count) % OUT_BYTES));
      end
    end
  end
endmodule
